// File: rtl/alu512_issue_seq.sv
// ---------------------------------------------------------------------------
// alu512_issue_seq
//
// Issue/writeback sequencer wrapped around the 512-bit block ALU (ALU512).
// Owns a small file of 512-bit registers. It accepts one instruction at a
// time, presents reg[rd]/reg[rs] to the ALU and pulses start. It then waits
// for the ALU to report ready, writes the result back to rd and latches the
// carry/zero flags. A 16-bit host port loads and reads individual register
// words.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   host_we/host_reg/host_word/host_wdata
//                       host word write (honoured only while idle)
//   host_rdata          registered read of reg[host_reg] word host_word
//   instr_valid/instr_ready
//                       instruction handshake
//   instr_op/rd/rs/size/off1/off2
//                       instruction fields
//   alu_in1/alu_in2     live operands reg[rd] / reg[rs]
//   alu_carry_in        architectural carry flag
//   alu_op_size/alu_op_offset1/alu_op_offset2/alu_operation
//                       latched instruction fields
//   alu_start           one-cycle start pulse
//   alu_rst             active-high ALU reset (~rst_n)
//   alu_res/alu_carry/alu_zero/alu_ready
//                       ALU result, flags and not-busy indication
//   carry_flag/zero_flag
//                       architectural flags
//   busy                high whenever the sequencer is not idle
//   instr_illegal       one-cycle pulse after an opcode 0xE/0xF is rejected
// ---------------------------------------------------------------------------
module alu512_issue_seq #(
  parameter int NREGS  = 8,
  parameter int RSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_we,
  input  logic [RSEL_W-1:0] host_reg,
  input  logic [4:0]        host_word,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [RSEL_W-1:0] instr_rd,
  input  logic [RSEL_W-1:0] instr_rs,
  input  logic [4:0]        instr_size,
  input  logic [4:0]        instr_off1,
  input  logic [4:0]        instr_off2,
  output logic [511:0]      alu_in1,
  output logic [511:0]      alu_in2,
  output logic              alu_carry_in,
  output logic [4:0]        alu_op_size,
  output logic [4:0]        alu_op_offset1,
  output logic [4:0]        alu_op_offset2,
  output logic [3:0]        alu_operation,
  output logic              alu_start,
  output logic              alu_rst,
  input  logic [511:0]      alu_res,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_ready,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              busy,
  output logic              instr_illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]        state;
  logic [511:0]      regs [NREGS];
  logic [3:0]        op_q;
  logic [RSEL_W-1:0] rd_q;
  logic [RSEL_W-1:0] rs_q;
  logic [4:0]        size_q;
  logic [4:0]        off1_q;
  logic [4:0]        off2_q;
  logic              carry_q;
  logic              zero_q;
  logic              illegal_q;
  logic [15:0]       rdata_q;
  logic              accept;
  logic              op_bad;
  logic [8:0]        host_bit;

  assign instr_ready = (state == S_IDLE) & rst_n;
  assign accept      = instr_valid & instr_ready;
  assign op_bad      = (instr_op >= 4'hE);
  // Word 31 maps to bits 511:496; the 9-bit bit index never exceeds 496.
  assign host_bit    = {host_word, 4'b0000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      size_q    <= '0;
      off1_q    <= '0;
      off2_q    <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      illegal_q <= 1'b0;
      // Read samples the pre-write contents, so a same-cycle write to the
      // same word returns the old value.
      rdata_q   <= regs[host_reg][host_bit +: 16];

      // Host writes are only honoured while idle. This keeps the operands
      // stable from accept to writeback.
      if (state == S_IDLE && host_we) begin
        regs[host_reg][host_bit +: 16] <= host_wdata;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= instr_op;
            rd_q   <= instr_rd;
            rs_q   <= instr_rs;
            size_q <= instr_size;
            off1_q <= instr_off1;
            off2_q <= instr_off2;
            if (op_bad) begin
              illegal_q <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // For MUL the ALU drops ready on the start edge, so this state
          // spans the whole multiply.
          if (alu_ready) begin
            state <= S_WB;
          end
        end
        S_WB: begin
          regs[rd_q] <= alu_res;
          carry_q    <= alu_carry;
          zero_q     <= alu_zero;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_in1        = regs[rd_q];
  assign alu_in2        = regs[rs_q];
  assign alu_carry_in   = carry_q;
  assign alu_op_size    = size_q;
  assign alu_op_offset1 = off1_q;
  assign alu_op_offset2 = off2_q;
  assign alu_operation  = op_q;
  assign alu_start      = (state == S_ISSUE) & rst_n;
  assign alu_rst        = ~rst_n;
  assign carry_flag     = carry_q;
  assign zero_flag      = zero_q;
  assign busy           = (state != S_IDLE);
  assign instr_illegal  = illegal_q;
  assign host_rdata     = rdata_q;

endmodule

// File: tb/tb_alu512_issue_seq.sv
module tb_alu512_issue_seq;
  localparam int NREGS  = 8;
  localparam int RSEL_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              host_we;
  logic [RSEL_W-1:0] host_reg;
  logic [4:0]        host_word;
  logic [15:0]       host_wdata;
  logic [15:0]       host_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [RSEL_W-1:0] instr_rd;
  logic [RSEL_W-1:0] instr_rs;
  logic [4:0]        instr_size;
  logic [4:0]        instr_off1;
  logic [4:0]        instr_off2;
  logic [511:0]      alu_in1;
  logic [511:0]      alu_in2;
  logic              alu_carry_in;
  logic [4:0]        alu_op_size;
  logic [4:0]        alu_op_offset1;
  logic [4:0]        alu_op_offset2;
  logic [3:0]        alu_operation;
  logic              alu_start;
  logic              alu_rst;
  logic [511:0]      alu_res;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_ready;
  logic              carry_flag;
  logic              zero_flag;
  logic              busy;
  logic              instr_illegal;

  always #5 clk = ~clk;

  alu512_issue_seq #(.NREGS(NREGS), .RSEL_W(RSEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_we(host_we), .host_reg(host_reg), .host_word(host_word),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_size(instr_size),
    .instr_off1(instr_off1), .instr_off2(instr_off2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry_in(alu_carry_in),
    .alu_op_size(alu_op_size), .alu_op_offset1(alu_op_offset1),
    .alu_op_offset2(alu_op_offset2), .alu_operation(alu_operation),
    .alu_start(alu_start), .alu_rst(alu_rst),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_ready(alu_ready),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .busy(busy),
    .instr_illegal(instr_illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk512(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Word-oriented ALU behaviour (ADD, ADC, MUL on 16-bit words).
  // Returns {carry, zero, result}.
  function automatic logic [513:0] alu_ref(input logic [3:0] op, input logic [511:0] a,
                                           input logic [511:0] b, input logic cin,
                                           input logic [4:0] sz, input logic [4:0] o1,
                                           input logic [4:0] o2);
    logic [511:0] r;
    logic         c;
    logic         z;
    logic [16:0]  s;
    logic [31:0]  p;
    r = a;
    c = 1'b0;
    z = 1'b1;
    if (op == 4'h0 || op == 4'h2) begin
      c = (op == 4'h2) ? cin : 1'b0;
      for (int i = 0; i <= int'(sz); i++) begin
        if (int'(o1) + i < 32 && int'(o2) + i < 32) begin
          s = {1'b0, a[16*(int'(o1)+i) +: 16]} + {1'b0, b[16*(int'(o2)+i) +: 16]} + {16'd0, c};
          r[16*(int'(o1)+i) +: 16] = s[15:0];
          c = s[16];
          if (s[15:0] != 16'd0) z = 1'b0;
        end
      end
    end else if (op == 4'h8) begin
      p = a[16*int'(o1) +: 16] * b[16*int'(o2) +: 16];
      r[16*int'(o1) +: 16] = p[15:0];
      z = (p == 32'd0);
    end
    return {c, z, r};
  endfunction

  // ALU stand-in: captures the result on start; MUL keeps ready low for mul_lat cycles.
  logic [511:0] s_res;
  logic         s_c;
  logic         s_z;
  int           s_cnt;
  int           mul_lat = 4;

  always @(posedge clk) begin
    if (alu_rst) begin
      s_res <= '0;
      s_c   <= 1'b0;
      s_z   <= 1'b0;
      s_cnt <= 0;
    end else if (alu_start) begin
      {s_c, s_z, s_res} <= alu_ref(alu_operation, alu_in1, alu_in2, alu_carry_in,
                                   alu_op_size, alu_op_offset1, alu_op_offset2);
      s_cnt <= (alu_operation == 4'h8) ? mul_lat : 0;
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
    end
  end

  assign alu_res   = s_res;
  assign alu_carry = s_c;
  assign alu_zero  = s_z;
  assign alu_ready = (s_cnt == 0);

  // Reference model state.
  logic [511:0] mreg [NREGS];
  logic         mcarry = 1'b0;
  logic         mzero  = 1'b0;
  logic         m_idle = 1'b1;
  logic [513:0] m_pred;
  logic [3:0]   e_op;
  logic [2:0]   e_rd;
  logic [2:0]   e_rs;
  logic [4:0]   e_size;
  logic [4:0]   e_off1;
  logic [4:0]   e_off2;
  int           start_cnt = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("alu_rst_run", 64'(alu_rst), 64'd0);
      if (m_idle) begin
        chk("ready_idle", 64'(instr_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("carry_flag", 64'(carry_flag), 64'(mcarry));
        chk("zero_flag", 64'(zero_flag), 64'(mzero));
      end
      if (!alu_ready) chk("busy_while_alu_busy", 64'(busy), 64'd1);
      if (alu_start) begin
        start_cnt++;
        chk512("alu_in1", alu_in1, mreg[e_rd]);
        chk512("alu_in2", alu_in2, mreg[e_rs]);
        chk("alu_carry_in", 64'(alu_carry_in), 64'(mcarry));
        chk("alu_operation", 64'(alu_operation), 64'(e_op));
        chk("alu_fields", 64'({alu_op_size, alu_op_offset1, alu_op_offset2}),
            64'({e_size, e_off1, e_off2}));
      end
    end else begin
      chk("ready_in_reset", 64'(instr_ready), 64'd0);
      chk("alu_rst_in_reset", 64'(alu_rst), 64'd1);
      chk("start_in_reset", 64'(alu_start), 64'd0);
    end
  end

  task automatic host_write(input int r, input int w, input logic [15:0] d);
    @(negedge clk);
    host_we    = 1'b1;
    host_reg   = 3'(r);
    host_word  = 5'(w);
    host_wdata = d;
    @(posedge clk);
    if (m_idle) mreg[r][16*w +: 16] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic read_word(input int r, input int w, output logic [15:0] v);
    @(negedge clk);
    host_reg  = 3'(r);
    host_word = 5'(w);
    @(posedge clk);
    @(negedge clk);
    v = host_rdata;
    chk("host_read_model", 64'(v), 64'(mreg[r][16*w +: 16]));
  endtask

  task automatic accept(input logic [3:0] op, input int rd, input int rs, input int sz,
                        input int o1, input int o2);
    @(negedge clk);
    e_op        = op;
    e_rd        = 3'(rd);
    e_rs        = 3'(rs);
    e_size      = 5'(sz);
    e_off1      = 5'(o1);
    e_off2      = 5'(o2);
    start_cnt   = 0;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = 3'(rd);
    instr_rs    = 3'(rs);
    instr_size  = 5'(sz);
    instr_off1  = 5'(o1);
    instr_off2  = 5'(o2);
    @(posedge clk);
    if (op < 4'hE) begin
      m_idle = 1'b0;
      m_pred = alu_ref(op, mreg[rd], mreg[rs], mcarry, 5'(sz), 5'(o1), 5'(o2));
    end
    #1 instr_valid = 1'b0;
  endtask

  task automatic finish_instr(input int exp_lows);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        done = 1;
        break;
      end
      n++;
    end
    chk("instr_done_in_budget", 64'(done), 64'd1);
    chk("ready_low_cycles", 64'(n), 64'(exp_lows));
    chk("single_start", 64'(start_cnt), 64'd1);
    mreg[e_rd] = m_pred[511:0];
    mcarry     = m_pred[513];
    mzero      = m_pred[512];
    m_idle     = 1'b1;
  endtask

  logic [15:0] v;

  initial begin
    for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    rst_n       = 1'b0;
    host_we     = 1'b0;
    host_reg    = '0;
    host_word   = '0;
    host_wdata  = '0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    instr_size  = '0;
    instr_off1  = '0;
    instr_off2  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_carry", 64'(carry_flag), 64'd0);
    chk("rst_zero", 64'(zero_flag), 64'd0);
    chk("rst_rdata", 64'(host_rdata), 64'd0);
    chk("rst_illegal", 64'(instr_illegal), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with carry out and zero result
    host_write(1, 0, 16'hFFFF);
    host_write(1, 1, 16'h5555);
    host_write(2, 0, 16'h0001);
    accept(4'h0, 1, 2, 0, 0, 0);
    finish_instr(3);
    read_word(1, 0, v);
    chk("add_r1w0_lit", 64'(v), 64'h0000);
    read_word(1, 1, v);
    chk("add_r1w1_lit", 64'(v), 64'h5555);
    chk("add_carry_lit", 64'(carry_flag), 64'd1);
    chk("add_zero_lit", 64'(zero_flag), 64'd1);

    // ADC consumes the carry from the ADD
    host_write(3, 0, 16'h0001);
    host_write(4, 0, 16'h0002);
    accept(4'h2, 3, 4, 0, 0, 0);
    finish_instr(3);
    read_word(3, 0, v);
    chk("adc_r3w0_lit", 64'(v), 64'h0004);
    chk("adc_carry_lit", 64'(carry_flag), 64'd0);
    chk("adc_zero_lit", 64'(zero_flag), 64'd0);

    // MUL stall with a host write dropped during WAIT
    host_write(5, 0, 16'h0003);
    host_write(6, 0, 16'h0005);
    mul_lat = 4;
    accept(4'h8, 5, 6, 0, 0, 0);
    fork
      finish_instr(7);
      begin
        @(negedge clk);
        host_write(5, 0, 16'hAAAA);
      end
    join
    read_word(5, 0, v);
    chk("mul_r5w0_lit", 64'(v), 64'h000F);

    // Offset placement
    host_write(1, 2, 16'h1234);
    accept(4'h0, 1, 2, 0, 2, 0);
    finish_instr(3);
    read_word(1, 2, v);
    chk("off_r1w2_lit", 64'(v), 64'h1235);
    read_word(1, 0, v);
    chk("off_r1w0_lit", 64'(v), 64'h0000);
    read_word(1, 1, v);
    chk("off_r1w1_lit", 64'(v), 64'h5555);

    // Top word boundary
    host_write(7, 31, 16'hBEEF);
    read_word(7, 31, v);
    chk("w31_lit", 64'(v), 64'hBEEF);
    read_word(7, 30, v);
    chk("w30_lit", 64'(v), 64'h0000);

    // Illegal opcode
    accept(4'hE, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("illegal_pulse", 64'(instr_illegal), 64'd1);
    chk("illegal_ready", 64'(instr_ready), 64'd1);
    @(negedge clk);
    chk("illegal_pulse_end", 64'(instr_illegal), 64'd0);
    chk("illegal_no_start", 64'(start_cnt), 64'd0);
    read_word(1, 2, v);
    chk("illegal_r1w2_lit", 64'(v), 64'h1235);

    // Reset in the middle of a MUL
    mul_lat = 10;
    accept(4'h8, 5, 6, 0, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    mcarry = 1'b0;
    mzero  = 1'b0;
    m_idle = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rdata", 64'(host_rdata), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    read_word(5, 0, v);
    chk("midrst_r5w0_lit", 64'(v), 64'h0000);
    read_word(1, 1, v);
    chk("midrst_r1w1_lit", 64'(v), 64'h0000);
    chk("midrst_carry_lit", 64'(carry_flag), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
